// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding bus request at a time,
// responses land in a DEPTH-entry FIFO that feeds decode through valid/ready.
module fetch_prefetch_queue #(
   parameter int                ADDR_W  = 64,
   parameter int                INST_W  = 32,
   parameter int                DEPTH   = 4,
   parameter logic [ADDR_W-1:0] PC_INIT = 64'h8000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     ireq_valid,
   output logic [ADDR_W-1:0]        ireq_addr,
   input  logic                     iresp_addr_ok,
   input  logic                     iresp_data_ok,
   input  logic [INST_W-1:0]        iresp_data,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INST_W-1:0]        out_inst,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C       = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE       = PTR_W'(1);
   localparam logic [ADDR_W-1:0] PC_STEP       = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = ~ADDR_W'(3);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state_q, state_d;
   logic                ireq_valid_q, ireq_valid_d;
   logic [ADDR_W-1:0]   ireq_addr_q, ireq_addr_d;
   logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic                drop_q, drop_d;
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [PTR_W-1:0]    rptr_q, rptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                out_valid_q, out_valid_d;
   logic [INST_W-1:0]   out_inst_q, out_inst_d;
   logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

   logic [INST_W-1:0]   mem_inst [DEPTH];
   logic [ADDR_W-1:0]   mem_pc   [DEPTH];

   logic resp;
   logic push;
   logic pop;

   // A response completes either in WAIT or in REQ when both handshakes coincide.
   assign resp = ((state_q == REQ) && iresp_addr_ok && iresp_data_ok) ||
                 ((state_q == WAIT) && iresp_data_ok);
   assign push = resp && !drop_q && !redirect_valid;
   assign pop  = out_valid_q && out_ready && !redirect_valid;

   always_comb begin
      state_d      = state_q;
      ireq_valid_d = ireq_valid_q;
      ireq_addr_d  = ireq_addr_q;
      req_pc_d     = req_pc_q;
      fetch_pc_d   = fetch_pc_q;
      drop_d       = drop_q;

      case (state_q)
         IDLE: begin
            if (!redirect_valid && (count_q < DEPTH_C)) begin
               state_d      = REQ;
               ireq_valid_d = 1'b1;
               ireq_addr_d  = fetch_pc_q;
               req_pc_d     = fetch_pc_q;
            end
         end
         REQ: begin
            // The request stays on the bus until accepted, redirect or not.
            if (iresp_addr_ok) begin
               ireq_valid_d = 1'b0;
               state_d      = iresp_data_ok ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (iresp_data_ok) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            ireq_valid_d = 1'b0;
         end
      endcase

      if (resp && drop_q) begin
         drop_d = 1'b0;
      end
      if (push) begin
         fetch_pc_d = req_pc_q + PC_STEP;
      end

      // A response finishing in the redirect cycle is discarded right here,
      // so drop only needs to cover a response that is still pending.
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & PC_ALIGN_MASK;
         drop_d     = (state_q != IDLE) && !resp;
      end
   end

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;

      if (redirect_valid) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + PTR_ONE;
         end
         if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase

         out_valid_d = (count_d != '0);
         // Head register holds the last shown entry while the queue is empty.
         if (count_d != '0) begin
            if (push && (rptr_d == wptr_q)) begin
               out_inst_d = iresp_data;
               out_pc_d   = req_pc_q;
            end else begin
               out_inst_d = mem_inst[rptr_d];
               out_pc_d   = mem_pc[rptr_d];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wptr_q] <= iresp_data;
         mem_pc[wptr_q]   <= req_pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ireq_valid_q <= 1'b0;
         ireq_addr_q  <= PC_INIT;
         req_pc_q     <= PC_INIT;
         fetch_pc_q   <= PC_INIT;
         drop_q       <= 1'b0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_inst_q   <= '0;
         out_pc_q     <= PC_INIT;
      end else begin
         state_q      <= state_d;
         ireq_valid_q <= ireq_valid_d;
         ireq_addr_q  <= ireq_addr_d;
         req_pc_q     <= req_pc_d;
         fetch_pc_q   <= fetch_pc_d;
         drop_q       <= drop_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_inst_q   <= out_inst_d;
         out_pc_q     <= out_pc_d;
      end
   end

   assign ireq_valid = ireq_valid_q;
   assign ireq_addr  = ireq_addr_q;
   assign out_valid  = out_valid_q;
   assign out_inst   = out_inst_q;
   assign out_pc     = out_pc_q;
   assign count      = count_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a queue-based model of the fetch
// front-end is compared against the DUT every cycle, plus literal spot checks.
module tb_fetch_prefetch_queue;

   localparam int          ADDR_W  = 64;
   localparam int          INST_W  = 32;
   localparam int          DEPTH   = 4;
   localparam logic [63:0] PC_INIT = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_pc;
   logic [2:0]  count;

   always #5 clk = ~clk;

   fetch_prefetch_queue #(
      .ADDR_W  (ADDR_W),
      .INST_W  (INST_W),
      .DEPTH   (DEPTH),
      .PC_INIT (PC_INIT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_addr_ok  (iresp_addr_ok),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .count          (count)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
   } ent_t;

   // Model: a queue of delivered instructions plus the one pending request.
   ent_t        m_q[$];
   logic        m_pres;
   logic        m_infl;
   logic        m_drop;
   logic [63:0] m_req_addr;
   logic [63:0] m_fetch_pc;
   logic [63:0] m_last_pc;
   logic [31:0] m_last_inst;

   int bus_cnt;
   int addr_lat;
   int data_lat;
   int checks;
   int failures;
   int cyc;

   logic        prev_ireq_valid;
   logic [63:0] issued[$];
   logic [63:0] popped_pc[$];
   logic [63:0] popped_inst[$];

   function automatic logic [31:0] bus_data(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9bdf;
   endfunction

   function automatic logic [63:0] at(input logic [63:0] qq[$], input int i);
      return (i < qq.size()) ? qq[i] : 64'hdead_dead_dead_dead;
   endfunction

   function automatic int occurrences(input logic [63:0] qq[$], input logic [63:0] v);
      int n = 0;
      foreach (qq[i]) if (qq[i] == v) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pres      = 1'b0;
      m_infl      = 1'b0;
      m_drop      = 1'b0;
      m_req_addr  = PC_INIT;
      m_fetch_pc  = PC_INIT;
      m_last_pc   = PC_INIT;
      m_last_inst = '0;
      bus_cnt     = 0;
   endtask

   task automatic model_edge();
      bit   do_pop, do_resp, do_issue;
      ent_t e;
      do_pop   = (m_q.size() > 0) && out_ready;
      do_resp  = (m_pres && iresp_addr_ok && iresp_data_ok) || (m_infl && iresp_data_ok);
      do_issue = !m_pres && !m_infl && (m_q.size() < DEPTH) && !redirect_valid;
      if (redirect_valid) begin
         m_q.delete();
         m_fetch_pc = {redirect_pc[63:2], 2'b00};
         m_drop     = (m_pres || m_infl) && !do_resp;
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (do_resp) begin
            if (m_drop) begin
               m_drop = 1'b0;
            end else begin
               e.inst = iresp_data;
               e.pc   = m_req_addr;
               m_q.push_back(e);
               m_fetch_pc = m_req_addr + 64'd4;
            end
         end
      end
      if (m_pres && iresp_addr_ok) begin
         m_pres = 1'b0;
         m_infl = !iresp_data_ok;
      end else if (m_infl && iresp_data_ok) begin
         m_infl = 1'b0;
      end
      if (do_issue) begin
         m_pres     = 1'b1;
         m_req_addr = m_fetch_pc;
         bus_cnt    = 0;
      end else if (m_pres || m_infl) begin
         bus_cnt++;
      end
      if (m_q.size() > 0) begin
         m_last_inst = m_q[0].inst;
         m_last_pc   = m_q[0].pc;
      end
   endtask

   task automatic drive_bus();
      iresp_addr_ok = m_pres && (bus_cnt >= addr_lat);
      iresp_data_ok = ((m_pres && iresp_addr_ok) || m_infl) && (bus_cnt >= data_lat);
      iresp_data    = bus_data(m_req_addr);
   endtask

   task automatic compare();
      chk("ireq_valid", 64'(ireq_valid), 64'(m_pres));
      chk("ireq_addr", ireq_addr, m_req_addr);
      chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("out_inst", 64'(out_inst), 64'(m_last_inst));
      chk("out_pc", out_pc, m_last_pc);
      if (ireq_valid && !prev_ireq_valid) issued.push_back(ireq_addr);
      prev_ireq_valid = ireq_valid;
   endtask

   task automatic step();
      if (out_valid && out_ready && !redirect_valid) begin
         popped_pc.push_back(out_pc);
         popped_inst.push_back(64'(out_inst));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      compare();
      drive_bus();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic reset_literals(input string tag);
      chk({tag, "_ireq_valid"}, 64'(ireq_valid), 64'd0);
      chk({tag, "_ireq_addr"}, ireq_addr, 64'h8000_0000);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_inst"}, 64'(out_inst), 64'd0);
      chk({tag, "_out_pc"}, out_pc, 64'h8000_0000);
      chk({tag, "_count"}, 64'(count), 64'd0);
   endtask

   // Asserts reset (checked #1 later, before any clock edge), then releases.
   task automatic do_reset(input string tag);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      model_reset();
      #1;
      reset_literals(tag);
      compare();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive_bus();
      issued.delete();
      popped_pc.delete();
      popped_inst.delete();
   endtask

   initial begin
      int n;
      checks = 0;
      failures = 0;
      cyc = 0;
      prev_ireq_valid = 1'b0;
      addr_lat = 2;
      data_lat = 2;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b0;
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data = '0;
      #2;

      // Sequential fetch, bus answers 2 cycles after each request.
      do_reset("t1_rst");
      out_ready = 1'b1;
      step();
      chk("t1_first_req_valid", 64'(ireq_valid), 64'd1);
      run(25);
      chk("t1_issue0", at(issued, 0), 64'h8000_0000);
      chk("t1_issue1", at(issued, 1), 64'h8000_0004);
      chk("t1_issue2", at(issued, 2), 64'h8000_0008);
      chk("t1_pop_pc0", at(popped_pc, 0), 64'h8000_0000);
      chk("t1_pop_pc1", at(popped_pc, 1), 64'h8000_0004);
      chk("t1_pop_pc2", at(popped_pc, 2), 64'h8000_0008);
      chk("t1_pop_inst0", at(popped_inst, 0), 64'h9357_9bdf);
      chk("t1_pop_inst1", at(popped_inst, 1), 64'h9357_9bdb);
      chk("t1_pop_inst2", at(popped_inst, 2), 64'h9357_9bd7);

      // Queue fills with decode stalled, then one pop restarts fetch.
      addr_lat = 0;
      data_lat = 0;
      do_reset("t2_rst");
      run(20);
      chk("t2_full_count", 64'(count), 64'd4);
      chk("t2_issued_n", 64'(issued.size()), 64'd4);
      chk("t2_idle_when_full", 64'(ireq_valid), 64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      run(6);
      chk("t2_issued_after_pop", 64'(issued.size()), 64'd5);
      chk("t2_next_addr", at(issued, 4), 64'h8000_0010);
      chk("t2_popped_head", at(popped_pc, 0), 64'h8000_0000);
      chk("t2_refilled", 64'(count), 64'd4);

      // Redirect while waiting for data of 0x8000_0008.
      addr_lat = 0;
      data_lat = 3;
      do_reset("t3_rst");
      out_ready = 1'b1;
      n = 0;
      while (!(m_infl && (m_req_addr == 64'h8000_0008)) && (n < 60)) begin
         step();
         n++;
      end
      chk("t3_reach_wait", 64'(n < 60), 64'd1);
      issued.delete();
      popped_pc.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1003;
      step();
      redirect_valid = 1'b0;
      chk("t3_flush_count", 64'(count), 64'd0);
      chk("t3_flush_valid", 64'(out_valid), 64'd0);
      run(30);
      chk("t3_next_issue", at(issued, 0), 64'h8000_1000);
      chk("t3_first_out", at(popped_pc, 0), 64'h8000_1000);
      chk("t3_dropped", 64'(occurrences(popped_pc, 64'h8000_0008)), 64'd0);

      // Redirect while the request waits for addr_ok (held low 3 cycles).
      addr_lat = 3;
      data_lat = 3;
      do_reset("t4_rst");
      out_ready = 1'b1;
      n = 0;
      while (!(m_pres && (m_req_addr == 64'h8000_0004) && (bus_cnt == 0)) && (n < 60)) begin
         step();
         n++;
      end
      chk("t4_reach_req", 64'(n < 60), 64'd1);
      issued.delete();
      popped_pc.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      step();
      redirect_valid = 1'b0;
      chk("t4_held_valid", 64'(ireq_valid), 64'd1);
      chk("t4_held_addr_a", ireq_addr, 64'h8000_0004);
      step();
      chk("t4_held_addr_b", ireq_addr, 64'h8000_0004);
      run(30);
      chk("t4_next_issue", at(issued, 0), 64'h8000_2000);
      chk("t4_first_out", at(popped_pc, 0), 64'h8000_2000);
      chk("t4_dropped", 64'(occurrences(popped_pc, 64'h8000_0004)), 64'd0);

      // Same-cycle addr_ok/data_ok together with a pop at count=2.
      addr_lat = 0;
      data_lat = 0;
      do_reset("t5_rst");
      n = 0;
      while (!((m_q.size() == 2) && m_pres) && (n < 60)) begin
         step();
         n++;
      end
      chk("t5_reach", 64'(n < 60), 64'd1);
      chk("t5_count_before", 64'(count), 64'd2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t5_count_same", 64'(count), 64'd2);
      chk("t5_head", out_pc, 64'h8000_0004);
      out_ready = 1'b1;
      run(3);
      chk("t5_pop0", at(popped_pc, 0), 64'h8000_0000);
      chk("t5_pop1", at(popped_pc, 1), 64'h8000_0004);
      chk("t5_pop2", at(popped_pc, 2), 64'h8000_0008);

      // Back-to-back redirects; the last one wins and the PC wraps past 2^64.
      issued.delete();
      popped_pc.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h9000_0000;
      step();
      redirect_pc    = 64'hffff_ffff_ffff_ffff;
      step();
      redirect_valid = 1'b0;
      run(30);
      chk("t6_issue0", at(issued, 0), 64'hffff_ffff_ffff_fffc);
      chk("t6_issue1", at(issued, 1), 64'h0000_0000_0000_0000);
      chk("t6_pop0", at(popped_pc, 0), 64'hffff_ffff_ffff_fffc);
      chk("t6_pop1", at(popped_pc, 1), 64'h0000_0000_0000_0000);

      // Reset asserted while a response is outstanding.
      addr_lat = 0;
      data_lat = 5;
      out_ready = 1'b1;
      n = 0;
      while (!m_infl && (n < 60)) begin
         step();
         n++;
      end
      chk("t7_reach_wait", 64'(n < 60), 64'd1);
      do_reset("t7_rst");
      out_ready = 1'b1;
      n = 0;
      while ((issued.size() == 0) && (n < 10)) begin
         step();
         n++;
      end
      chk("t7_first_issue", at(issued, 0), 64'h8000_0000);
      run(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
